// File: rtl/kf6845_pkg.sv
`timescale 1ns/1ps
// Shared defaults and interlace mode encoding for the KF6845 vertical timing block.
package kf6845_pkg;

    localparam int ROW_W_DEFAULT = 7;
    localparam int RA_W_DEFAULT  = 5;
    localparam int VSW_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        NORMAL               = 2'b00,
        INTERLACE_SYNC       = 2'b01,
        INTERLACE_SYNC_VIDEO = 2'b11
    } interlace_mode_e;

endpackage

// File: rtl/kf6845_vsync_gen.sv
`timescale 1ns/1ps
// VSYNC pulse generator: line-counted odd-field pulse plus a half-line delayed
// copy used on the even field.
module kf6845_vsync_gen
    import kf6845_pkg::*;
#(
    parameter int VSW_W = VSW_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             video_clock_enable,
    input  logic             Horizontal_Half,
    input  logic             line_tick,
    input  logic             start,
    input  logic             field,
    input  logic [VSW_W-1:0] vsync_width,
    output logic             VSYNC
);

    localparam logic [VSW_W:0] CNT_ONE  = (VSW_W+1)'(1);
    localparam logic [VSW_W:0] CNT_FULL = {1'b1, {VSW_W{1'b0}}};

    logic [VSW_W:0] count_q, count_d;
    logic           vsync_odd_q, vsync_odd_d;
    logic           vsync_even_q, vsync_even_d;

    always_comb begin
        count_d      = count_q;
        vsync_odd_d  = vsync_odd_q;
        vsync_even_d = vsync_even_q;
        if (line_tick) begin
            if (start) begin
                // A width of zero encodes the longest pulse, 2^VSW_W lines.
                count_d     = (vsync_width == '0) ? CNT_FULL : {1'b0, vsync_width};
                vsync_odd_d = 1'b1;
            end else if (vsync_odd_q) begin
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    vsync_odd_d = 1'b0;
                end
            end
        end
        if (video_clock_enable && Horizontal_Half) begin
            vsync_even_d = vsync_odd_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            vsync_odd_q  <= 1'b0;
            vsync_even_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            vsync_odd_q  <= vsync_odd_d;
            vsync_even_q <= vsync_even_d;
        end
    end

    assign VSYNC = field ? vsync_odd_q : vsync_even_q;

endmodule

// File: rtl/kf6845_vertical_timing.sv
`timescale 1ns/1ps
// KF6845 vertical timing: scan/row counters, total-adjust and interlace field
// sequencing, display enable, raster address and line-compare strobe.
module kf6845_vertical_timing
    import kf6845_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEFAULT,
    parameter int RA_W  = RA_W_DEFAULT,
    parameter int VSW_W = VSW_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             video_clock_enable,
    input  logic [7:0]       internal_data_bus,
    input  logic             write_vertical_total,
    input  logic             write_vertical_total_adjust,
    input  logic             write_vertical_displayed,
    input  logic             write_vertical_sync_position,
    input  logic             write_interlace_mode,
    input  logic             write_maximum_scan_line,
    input  logic             write_vsync_width,
    input  logic             write_line_compare,
    input  logic             Horizontal,
    input  logic             Horizontal_Half,
    output logic [1:0]       interlace,
    output logic             field,
    output logic             V_total,
    output logic             V_Display,
    output logic             Scanline_End,
    output logic [RA_W-1:0]  RA,
    output logic [ROW_W-1:0] row,
    output logic             VSYNC,
    output logic             line_match
);

    localparam logic [RA_W-1:0]  RA_ONE  = RA_W'(1);
    localparam logic [RA_W-1:0]  RA_TWO  = RA_W'(2);
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

    logic [ROW_W-1:0] vertical_total_q, vertical_displayed_q, sync_position_q, line_compare_q;
    logic [RA_W-1:0]  adjust_q, max_scan_q;
    logic [1:0]       interlace_mode_q;
    logic [VSW_W-1:0] vsync_width_q;

    logic [RA_W-1:0]  scan_q, scan_d, ra_q, ra_d;
    logic [ROW_W-1:0] row_q, next_row;
    logic             adjust_phase_q, adjust_phase_d;
    logic             v_display_q, v_display_d;
    logic [1:0]       interlace_q, interlace_d;
    logic             field_q, field_d;

    logic             line_tick, vt_odd, vt_even, vsync_start;
    logic             unused_bus;

    assign unused_bus = ^internal_data_bus;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vertical_total_q     <= '0;
            adjust_q             <= '0;
            vertical_displayed_q <= '0;
            sync_position_q      <= '1;
            interlace_mode_q     <= '0;
            max_scan_q           <= '0;
            vsync_width_q        <= '0;
            line_compare_q       <= '0;
        end else begin
            if (write_vertical_total)         vertical_total_q     <= internal_data_bus[ROW_W-1:0];
            if (write_vertical_total_adjust)  adjust_q             <= internal_data_bus[RA_W-1:0];
            if (write_vertical_displayed)     vertical_displayed_q <= internal_data_bus[ROW_W-1:0];
            if (write_vertical_sync_position) sync_position_q      <= internal_data_bus[ROW_W-1:0];
            if (write_interlace_mode)         interlace_mode_q     <= internal_data_bus[1:0];
            if (write_maximum_scan_line)      max_scan_q           <= internal_data_bus[RA_W-1:0];
            if (write_vsync_width)            vsync_width_q        <= internal_data_bus[VSW_W-1:0];
            if (write_line_compare)           line_compare_q       <= internal_data_bus[ROW_W-1:0];
        end
    end

    // Reset also masks the strobe so no combinational pulse escapes during reset.
    assign line_tick    = video_clock_enable & Horizontal & reset_n;
    assign Scanline_End = line_tick & (scan_q == max_scan_q);

    assign vt_odd  = (adjust_q == '0)
                   ? (Scanline_End & (row_q == vertical_total_q))
                   : (line_tick & adjust_phase_q & (scan_q == adjust_q - RA_ONE));
    assign vt_even = line_tick & adjust_phase_q & (scan_q == adjust_q);
    assign V_total = field_q ? vt_odd : vt_even;

    assign next_row    = V_total ? '0 : (Scanline_End ? row_q + ROW_ONE : row_q);
    assign line_match  = Scanline_End & (next_row == line_compare_q);
    assign vsync_start = Scanline_End & (next_row == sync_position_q);

    always_comb begin
        scan_d         = scan_q;
        ra_d           = ra_q;
        adjust_phase_d = adjust_phase_q;
        v_display_d    = v_display_q;
        interlace_d    = interlace_q;
        field_d        = field_q;

        if (V_total) begin
            interlace_d = interlace_mode_q;
            field_d     = interlace_mode_q[0] ? ~field_q : 1'b1;
        end

        if (V_total) begin
            adjust_phase_d = 1'b0;
        end else if (Scanline_End && (row_q == vertical_total_q)) begin
            adjust_phase_d = 1'b1;
        end

        if (next_row == vertical_displayed_q) begin
            v_display_d = 1'b0;
        end else if (V_total) begin
            v_display_d = 1'b1;
        end

        if (line_tick) begin
            scan_d = (V_total || Scanline_End) ? '0 : scan_q + RA_ONE;
            // The reload uses the upcoming field so each frame starts on its own parity.
            if (V_total || Scanline_End) begin
                ra_d = ((interlace_d == INTERLACE_SYNC_VIDEO) && field_d) ? RA_ONE : '0;
            end else begin
                ra_d = ra_q + ((interlace_q == INTERLACE_SYNC_VIDEO) ? RA_TWO : RA_ONE);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_q         <= '0;
            row_q          <= '0;
            ra_q           <= '0;
            adjust_phase_q <= 1'b0;
            v_display_q    <= 1'b0;
            interlace_q    <= '0;
            field_q        <= 1'b1;
        end else begin
            scan_q         <= scan_d;
            row_q          <= next_row;
            ra_q           <= ra_d;
            adjust_phase_q <= adjust_phase_d;
            v_display_q    <= v_display_d;
            interlace_q    <= interlace_d;
            field_q        <= field_d;
        end
    end

    kf6845_vsync_gen #(
        .VSW_W(VSW_W)
    ) u_vsync_gen (
        .clock              (clock),
        .reset_n            (reset_n),
        .video_clock_enable (video_clock_enable),
        .Horizontal_Half    (Horizontal_Half),
        .line_tick          (line_tick),
        .start              (vsync_start),
        .field              (field_q),
        .vsync_width        (vsync_width_q),
        .VSYNC              (VSYNC)
    );

    assign interlace = interlace_q;
    assign field     = field_q;
    assign V_Display = v_display_q;
    assign RA        = ra_q;
    assign row       = row_q;

endmodule

// File: tb/tb_kf6845_vertical_timing.sv
`timescale 1ns/1ps
// Bench for kf6845_vertical_timing: a frame enumerator lists every scan line of
// each field; per-line expectations are queued and compared as each line ends.
module tb_kf6845_vertical_timing;
    import kf6845_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ven = 1'b0, hor = 1'b0, hhalf = 1'b0;
    logic [7:0] bus = 8'h00;
    logic [7:0] wstb = 8'h00;

    logic [1:0] interlace;
    logic       field, V_total, V_Display, Scanline_End, VSYNC, line_match;
    logic [4:0] RA;
    logic [6:0] row;

    kf6845_vertical_timing dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .video_clock_enable           (ven),
        .internal_data_bus            (bus),
        .write_vertical_total         (wstb[0]),
        .write_vertical_total_adjust  (wstb[1]),
        .write_vertical_displayed     (wstb[2]),
        .write_vertical_sync_position (wstb[3]),
        .write_interlace_mode         (wstb[4]),
        .write_maximum_scan_line      (wstb[5]),
        .write_vsync_width            (wstb[6]),
        .write_line_compare           (wstb[7]),
        .Horizontal                   (hor),
        .Horizontal_Half              (hhalf),
        .interlace                    (interlace),
        .field                        (field),
        .V_total                      (V_total),
        .V_Display                    (V_Display),
        .Scanline_End                 (Scanline_End),
        .RA                           (RA),
        .row                          (row),
        .VSYNC                        (VSYNC),
        .line_match                   (line_match)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         row;
        int         scan;
        logic       fld;
        logic [1:0] il;
        logic       last;
        logic       vs;
        logic       disp;
    } line_t;

    typedef struct {
        logic       se, vt, lm, fld, vd, vs;
        logic [1:0] il;
        int         row, ra;
    } exp_t;

    line_t lines[$];
    exp_t  sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    int         c_vt, c_adj, c_disp, c_ms, c_sp, c_vsw, c_lc;
    logic [1:0] c_mode;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int sel, input int val);
        if (val >= 0) begin
            bus  = 8'(val);
            wstb = 8'h01 << sel;
            step();
            wstb = 8'h00;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ven = 1'b0; hor = 1'b0; hhalf = 1'b0; wstb = 8'h00;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Negative arguments leave a register at its reset value.
    task automatic configure(input int vt, input int adj, input int disp, input int ms,
                             input int mode, input int sp, input int vsw, input int lc);
        do_reset();
        wr(0, vt); wr(1, adj); wr(2, disp); wr(3, sp);
        wr(4, mode); wr(5, ms); wr(6, vsw); wr(7, lc);
        c_vt   = vt;
        c_adj  = (adj  < 0) ? 0 : adj;
        c_disp = (disp < 0) ? 0 : disp;
        c_ms   = ms;
        c_mode = (mode < 0) ? 2'b00 : 2'(mode);
        c_sp   = (sp   < 0) ? 127 : (sp & 127);
        c_vsw  = (vsw  < 0) ? 0 : (vsw & 15);
        c_lc   = (lc   < 0) ? 0 : (lc & 127);
    endtask

    task automatic build(input int nframes);
        logic       f = 1'b1;
        logic [1:0] il = 2'b00;
        logic       seen = 1'b0;
        int         w  = (c_vsw == 0) ? 16 : c_vsw;
        int         k0 = c_sp * (c_ms + 1);
        line_t      lt;
        lines.delete();
        for (int fr = 0; fr < nframes; fr++) begin
            int nadj = f ? c_adj : c_adj + 1;
            int k = 0;
            for (int r = 0; r <= c_vt + 1; r++) begin
                int nscan = (r <= c_vt) ? c_ms + 1 : nadj;
                for (int s = 0; s < nscan; s++) begin
                    lt.row  = r;
                    lt.scan = s;
                    lt.fld  = f;
                    lt.il   = il;
                    lt.last = 1'b0;
                    lt.vs   = (c_sp <= c_vt) && (k >= k0) && (k < k0 + w);
                    lt.disp = seen && (r < c_disp);
                    lines.push_back(lt);
                    k++;
                end
            end
            lines[lines.size()-1].last = 1'b1;
            il   = c_mode;
            f    = c_mode[0] ? ~f : 1'b1;
            seen = 1'b1;
        end
    endtask

    function automatic int ra_of(input line_t l);
        if (l.il == 2'b11) return ((l.fld ? 1 : 0) + 2 * l.scan) % 32;
        return l.scan % 32;
    endfunction

    task automatic run_lines(input int nticks);
        exp_t e;
        for (int i = 0; i < nticks; i++) begin
            line_t cur = lines[i];
            line_t nx  = lines[i+1];
            e.se  = (cur.scan == c_ms);
            e.vt  = cur.last;
            e.lm  = e.se && (nx.row == c_lc);
            e.row = nx.row % 128;
            e.ra  = ra_of(nx);
            e.fld = nx.fld;
            e.il  = nx.il;
            e.vd  = nx.disp;
            e.vs  = nx.fld ? nx.vs : cur.vs;
            sb.push_back(e);

            // Four qualified clocks per line; the unqualified clock must do nothing.
            ven = 1'b1; hor = 1'b0; hhalf = 1'b0; step();
            ven = 1'b0; hor = 1'b1; hhalf = 1'b1; step();
            ven = 1'b1; hor = 1'b0; hhalf = 1'b1; step();
            hhalf = 1'b0; step();
            hor = 1'b1;
            #3;
            e = sb.pop_front();
            chk("Scanline_End", Scanline_End, e.se);
            chk("V_total", V_total, e.vt);
            chk("line_match", line_match, e.lm);
            step();
            hor = 1'b0;
            chk("row", row, e.row);
            chk("RA", RA, e.ra);
            chk("field", field, e.fld);
            chk("interlace", interlace, e.il);
            chk("V_Display", V_Display, e.vd);
            chk("VSYNC", VSYNC, e.vs);
        end
        ven = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ven = 1'b1; hor = 1'b1;
        #12;
        chk("rst_row", row, 0);
        chk("rst_RA", RA, 0);
        chk("rst_field", field, 1);
        chk("rst_VSYNC", VSYNC, 0);
        chk("rst_V_Display", V_Display, 0);
        chk("rst_interlace", interlace, 0);
        chk("rst_Scanline_End", Scanline_End, 0);
        chk("rst_V_total", V_total, 0);
        chk("rst_line_match", line_match, 0);

        // 8-line frames, 4 displayed lines, line compare through a wide bus value.
        configure(3, 0, 2, 1, 0, -1, -1, 8'h81);
        build(3);
        run_lines(lines.size() - 1);

        // Odd 10 / even 11 line fields with total adjust.
        configure(1, 2, 1, 3, 1, -1, -1, -1);
        build(4);
        run_lines(lines.size() - 1);

        // Interlace sync and video raster address parity.
        configure(1, 0, 2, 3, 3, -1, -1, -1);
        build(3);
        run_lines(lines.size() - 1);

        // Three-line VSYNC starting at row 2, sync position given with a high bus bit.
        configure(7, 0, 4, 3, 0, 8'h82, 3, 5);
        build(2);
        run_lines(lines.size() - 1);

        // Maximum-width VSYNC, then reset during the even-field pulse.
        configure(7, 0, 4, 3, 1, 2, 0, -1);
        build(2);
        run_lines(44);
        ven = 1'b1; hor = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_VSYNC", VSYNC, 0);
        chk("mid_rst_RA", RA, 0);
        chk("mid_rst_row", row, 0);
        chk("mid_rst_field", field, 1);
        chk("mid_rst_V_Display", V_Display, 0);
        chk("mid_rst_Scanline_End", Scanline_End, 0);
        chk("mid_rst_V_total", V_total, 0);
        chk("mid_rst_line_match", line_match, 0);
        ven = 1'b0; hor = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
